muldiv_unit: RTL and testbench

Parametrised multi-cycle integer multiply/divide unit for the execute stage, covering RV64M including the word (W) variants. It sits beside the single-cycle ALU. It accepts one operation at a time over a valid/ready handshake and returns the result over a second valid/ready handshake. A flush input lets the pipeline kill an in-flight operation on redirect. Multiplication is pipelined over a fixed number of stages; division is iterative, one quotient bit per cycle.

---
 rtl/muldiv_unit.sv | 202 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// RV64M multiply/divide beside the ALU: fixed-latency multiply, restoring divide one quotient bit per cycle.
// One operation in flight; valid/ready on input and output, flush kills the operation at the next edge.

module muldiv_unit #(
    parameter int WIDTH       = 64,
    parameter int MUL_LATENCY = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             word,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state_q;
    logic [2:0]       op_q;
    logic             word_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             spec_q;
    logic [WIDTH-1:0] res_q;

    function automatic logic [WIDTH-1:0] fmt_word(input logic [WIDTH-1:0] v, input logic w);
        logic [WIDTH-1:0] r;
        r = v;
        if (w) begin
            for (int i = 32; i < WIDTH; i++) r[i] = v[31];
        end
        return r;
    endfunction

    // Accept-side operand preparation
    logic             word_in;
    logic             sgn_div;
    logic             a_neg;
    logic             b_neg;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] a_ext;
    logic [WIDTH-1:0] b_ext;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] min_val;
    logic [WIDTH-1:0] spec_res;

    always_comb begin
        word_in = (WIDTH == 64) && word;
        sgn_div = (op == 4'd4) || (op == 4'd6);
        a_ext   = a;
        b_ext   = b;
        min_val = '0;
        min_val[WIDTH-1] = 1'b1;
        if (word_in) begin
            for (int i = 32; i < WIDTH; i++) begin
                a_ext[i] = sgn_div & a[31];
                b_ext[i] = sgn_div & b[31];
            end
            for (int i = 31; i < WIDTH; i++) min_val[i] = 1'b1;
        end
        a_neg    = sgn_div & a_ext[WIDTH-1];
        b_neg    = sgn_div & b_ext[WIDTH-1];
        mag_a    = a_neg ? (~a_ext + {{(WIDTH-1){1'b0}}, 1'b1}) : a_ext;
        mag_b    = b_neg ? (~b_ext + {{(WIDTH-1){1'b0}}, 1'b1}) : b_ext;
        div_zero = (b_ext == '0);
        div_ovf  = sgn_div && (a_ext == min_val) && (b_ext == '1);
        if (div_zero) spec_res = op[1] ? a_ext : '1;
        else          spec_res = op[1] ? '0 : a_ext;
        spec_res = fmt_word(spec_res, word_in);
    end

    // Multiplier works on the latched operands; the down-counter models its pipeline depth
    logic [PW-1:0]    ax;
    logic [PW-1:0]    bx;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] mul_res;

    always_comb begin
        ax   = {{WIDTH{(op_q == 3'd1 || op_q == 3'd2) && a_q[WIDTH-1]}}, a_q};
        bx   = {{WIDTH{(op_q == 3'd1) && b_q[WIDTH-1]}}, b_q};
        prod = ax * bx;
        if (op_q == 3'd0)  mul_res = fmt_word(prod[WIDTH-1:0], word_q);
        else if (word_q)   mul_res = '0;
        else               mul_res = prod[PW-1:WIDTH];
    end

    // One restoring step: shift the next dividend bit in, keep the difference if no borrow
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] div_res;

    always_comb begin
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, dvs_q};
        rem_d   = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        q_fix   = qneg_q ? (~quo_q + {{(WIDTH-1){1'b0}}, 1'b1}) : quo_q;
        r_fix   = rneg_q ? (~rem_q + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_q;
        div_res = fmt_word(op_q[1] ? r_fix : q_fix, word_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            word_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            spec_q  <= 1'b0;
            res_q   <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q   <= op[2:0];
                        word_q <= word_in;
                        a_q    <= a_ext;
                        b_q    <= b_ext;
                        dvs_q  <= mag_b;
                        rem_q  <= '0;
                        // W divides run 32 steps, so the dividend is pre-aligned to the top half
                        quo_q  <= word_in ? (mag_a << 32) : mag_a;
                        qneg_q <= a_neg ^ b_neg;
                        rneg_q <= a_neg;
                        spec_q <= 1'b0;
                        if (!op[3] && !op[2]) begin
                            cnt_q   <= CW'(MUL_LATENCY - 1);
                            state_q <= S_MUL;
                        end else if (op[3] || div_zero || div_ovf) begin
                            // Result is known now; it still takes the single sign-fix cycle
                            res_q   <= op[3] ? '0 : spec_res;
                            spec_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= S_DIV;
                        end else begin
                            cnt_q   <= word_in ? CW'(32) : CW'(WIDTH);
                            state_q <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == '0) begin
                        res_q   <= mul_res;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DIV: begin
                    if (cnt_q != '0) begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        if (!spec_q) res_q <= div_res;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=64, MUL_LATENCY=3): directed vectors, latency and result checks.
module tb_muldiv_unit;

    localparam int W = 64;

    logic         clk       = 1'b0;
    logic         resetn    = 1'b0;
    logic         in_valid  = 1'b0;
    logic         word      = 1'b0;
    logic         flush     = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   op        = 4'd0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [W-1:0] out_result;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        string       nm;
        logic [63:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    muldiv_unit #(.WIDTH(W), .MUL_LATENCY(3)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .word       (word),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: on every rising out_valid, pop the oldest expectation and compare
    initial begin : monitor
        logic vp;
        exp_t e;
        vp = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                vp = 1'b0;
            end else begin
                if (out_valid && !vp) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk({e.nm, "_latency"}, 64'(cyc - e.acc), 64'(e.lat));
                        chk({e.nm, "_result"}, out_result, e.res);
                    end
                end
                vp = out_valid;
            end
        end
    end

    task automatic issue(input string nm, input logic [3:0] o, input logic w,
                         input logic [63:0] x, input logic [63:0] y,
                         input logic [63:0] er, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        chk({nm, "_ready_before"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        op       = o;
        word     = w;
        a        = x;
        b        = y;
        if (push) begin
            e.nm  = nm;
            e.res = er;
            e.lat = lat;
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        op       = 4'd15;
        word     = ~w;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 300 && !in_ready; i++) @(negedge clk);
        chk({nm, "_back_to_idle"}, 64'(in_ready), 64'd1);
        chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic run(input string nm, input logic [3:0] o, input logic w,
                       input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] er, input int lat);
        issue(nm, o, w, x, y, er, lat, 1'b1);
        wait_idle(nm);
    endtask

    initial begin : stim
        bit seen;
        #1;
        chk("rst_in_ready",   64'(in_ready),  64'd1);
        chk("rst_busy",       64'(busy),      64'd0);
        chk("rst_out_valid",  64'(out_valid), 64'd0);
        chk("rst_out_result", out_result,     64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        run("mul",      4'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 3);
        run("mulhu",    4'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 3);
        run("mulh",     4'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        run("mulhsu",   4'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        run("div",      4'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run("rem",      4'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run("div_negb", 4'd4, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 65);
        run("rem_negb", 4'd6, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65);
        run("divu",     4'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        run("remu",     4'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65);
        run("divu_z",   4'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run("remu_z",   4'd7, 1'b0, 64'd5, 64'd0, 64'd5, 1);
        run("div_ovf",  4'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
        run("divw_ovf", 4'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        run("divuw",    4'd5, 1'b1, 64'd100, 64'd7, 64'd14, 33);
        run("remw",     4'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run("mulw",     4'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 3);
        run("mulhw",    4'd1, 1'b1, 64'd3, 64'd4, 64'd0, 3);
        run("illegal",  4'd9, 1'b0, 64'd3, 64'd4, 64'd0, 1);

        // Backpressure: result must hold while the consumer stalls
        out_ready = 1'b0;
        issue("bp_mul", 4'd0, 1'b0, 64'd6, 64'd7, 64'd42, 3, 1'b1);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("bp_valid_seen", 64'(out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_held",  64'(out_valid), 64'd1);
            chk("bp_result_held", out_result,     64'd42);
            chk("bp_in_ready",    64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready",  64'(in_ready),  64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        chk("bp_sb_empty",          64'(sb.size()), 64'd0);

        // Flush partway through a divide
        issue("flush_div", 4'd4, 1'b0, 64'd100, 64'd7, 64'd0, 0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready",  64'(in_ready),  64'd1);
        chk("flush_busy",      64'(busy),      64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_result", 64'(seen), 64'd0);

        // Flush coinciding with an offered operation
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        op       = 4'd5;
        word     = 1'b0;
        a        = 64'd5;
        b        = 64'd0;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_acc_in_ready",  64'(in_ready),  64'd1);
        chk("flush_acc_busy",      64'(busy),      64'd0);
        chk("flush_acc_out_valid", 64'(out_valid), 64'd0);
        repeat (5) @(negedge clk);
        chk("flush_acc_quiet", 64'(out_valid), 64'd0);

        // Asynchronous reset in the middle of a multiply
        issue("rst_mul", 4'd0, 1'b0, 64'd3, 64'd5, 64'd15, 3, 1'b0);
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_in_ready",   64'(in_ready),  64'd1);
        chk("mid_rst_busy",       64'(busy),      64'd0);
        chk("mid_rst_out_valid",  64'(out_valid), 64'd0);
        chk("mid_rst_out_result", out_result,     64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_quiet", 64'(out_valid), 64'd0);
        run("post_rst_mul", 4'd0, 1'b0, 64'd3, 64'd5, 64'd15, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
